spi_master_arbiter: RTL and testbench

- Shares one spi_master instance between two requesters (e.g. CPU-side SPI peripheral and a hardware config engine).
- Grants the master for a whole burst, byte-by-byte, until the requester's last byte.
- Per burst: loads the granted requester's clock divider/CPOL/CPHA into the master, sequences each byte via tx_data_valid, and returns each received byte to the owner.
- Exports current owner so top level can route ss to the correct slave.

---
 rtl/spi_master_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Two-port burst arbiter in front of a single spi_master: round-robin grant per burst,
// per-owner clock/mode load, byte sequencing. Define SPI_ARB_TIMEOUT_EN for the WAIT watchdog.
module spi_master_arbiter #(
  parameter int unsigned CLK_DIV_W      = 8,
  parameter int unsigned IDLE_GAP       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                req_valid_i,
  input  logic [1:0][7:0]           req_data_i,
  input  logic [1:0]                req_last_i,
  output logic [1:0]                req_ready_o,
  input  logic [1:0][CLK_DIV_W-1:0] cfg_div_i,
  input  logic [1:0]                cfg_cpol_i,
  input  logic [1:0]                cfg_cpha_i,
  output logic [1:0]                rsp_valid_o,
  output logic [7:0]                rsp_data_o,
  output logic                      owner_valid_o,
  output logic                      owner_o,
  output logic                      err_o,
  output logic                      m_tx_data_valid_o,
  output logic [7:0]                m_tx_data_o,
  output logic                      m_clk_divider_valid_o,
  output logic [CLK_DIV_W-1:0]      m_clk_divider_o,
  output logic                      m_cpol_o,
  output logic                      m_cpha_o,
  input  logic                      m_busy_i,
  input  logic                      m_rx_data_valid_i,
  input  logic [7:0]                m_rx_data_i
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCfg  = 3'd1;
  localparam logic [2:0] StSend = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StNext = 3'd4;
  localparam logic [2:0] StGap  = 3'd5;

  localparam logic [3:0] GapLast = 4'(IDLE_GAP - 1);

  logic [2:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 owner_valid_q, owner_valid_d;
  logic                 last_served_q, last_served_d;
  logic                 last_q, last_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [CLK_DIV_W-1:0] div_q, div_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic                 div_valid_q, div_valid_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [1:0]           req_ready_q, req_ready_d;
  logic [1:0]           rsp_valid_q, rsp_valid_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 grant;
  logic                 owner_go;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned    ToW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // On a tie the port that was not served last wins; a lone requester always wins.
  assign grant    = (req_valid_i == 2'b11) ? ~last_served_q : req_valid_i[1];
  assign owner_go = req_valid_i[owner_q] & ~m_busy_i;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    last_served_d = last_served_q;
    last_d        = last_q;
    gap_cnt_d     = gap_cnt_q;
    div_d         = div_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    tx_data_d     = tx_data_q;
    rsp_data_d    = rsp_data_q;
    div_valid_d   = 1'b0;
    tx_valid_d    = 1'b0;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    err_d         = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if ((|req_valid_i) && !m_busy_i) begin
          owner_d       = grant;
          owner_valid_d = 1'b1;
          div_d         = cfg_div_i[grant];
          cpol_d        = cfg_cpol_i[grant];
          cpha_d        = cfg_cpha_i[grant];
          div_valid_d   = 1'b1;
          state_d       = StCfg;
        end
      end

      // Register the start pulse and consume the byte in the same edge; SEND then shows both.
      StCfg, StNext: begin
        if (owner_go) begin
          tx_valid_d            = 1'b1;
          tx_data_d             = req_data_i[owner_q];
          req_ready_d[owner_q]  = 1'b1;
          last_d                = req_last_i[owner_q];
          state_d               = StSend;
        end else begin
          state_d = StNext;
        end
      end

      StSend: begin
        state_d = StWait;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end

      StWait: begin
        if (m_rx_data_valid_i) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = m_rx_data_i;
          if (last_q) begin
            owner_valid_d = 1'b0;
            last_served_d = owner_q;
            gap_cnt_d     = '0;
            state_d       = StGap;
          end else begin
            state_d = StNext;
          end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_cnt_q == ToLast) begin
          err_d         = 1'b1;
          owner_valid_d = 1'b0;
          last_served_d = owner_q;
          gap_cnt_d     = '0;
          state_d       = StGap;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end

      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      owner_valid_q <= 1'b0;
      last_served_q <= 1'b1;
      last_q        <= 1'b0;
      gap_cnt_q     <= '0;
      div_q         <= '0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      div_valid_q   <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      last_served_q <= last_served_d;
      last_q        <= last_d;
      gap_cnt_q     <= gap_cnt_d;
      div_q         <= div_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      div_valid_q   <= div_valid_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign req_ready_o           = req_ready_q;
  assign rsp_valid_o           = rsp_valid_q;
  assign rsp_data_o            = rsp_data_q;
  assign owner_valid_o         = owner_valid_q;
  assign owner_o               = owner_q;
  assign m_tx_data_valid_o     = tx_valid_q;
  assign m_tx_data_o           = tx_data_q;
  assign m_clk_divider_valid_o = div_valid_q;
  assign m_clk_divider_o       = div_q;
  assign m_cpol_o              = cpol_q;
  assign m_cpha_o              = cpha_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: queued requesters, loopback spi_master model, event logs
// compared against an expected burst schedule derived from round-robin rules.
module tb_spi_master_arbiter;

  localparam int IdleGap = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]      req_valid;
  logic [1:0][7:0] req_data;
  logic [1:0]      req_last;
  logic [1:0]      req_ready;
  logic [1:0][7:0] cfg_div;
  logic [1:0]      cfg_cpol, cfg_cpha;
  logic [1:0]      rsp_valid;
  logic [7:0]      rsp_data;
  logic            owner_valid, owner, err;
  logic            m_tx_data_valid, m_clk_divider_valid, m_cpol, m_cpha;
  logic [7:0]      m_tx_data, m_clk_divider;
  logic            m_busy, m_rx_data_valid;
  logic [7:0]      m_rx_data;

  spi_master_arbiter #(.CLK_DIV_W(8), .IDLE_GAP(IdleGap), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .cfg_div_i(cfg_div), .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .owner_valid_o(owner_valid),
    .owner_o(owner), .err_o(err),
    .m_tx_data_valid_o(m_tx_data_valid), .m_tx_data_o(m_tx_data),
    .m_clk_divider_valid_o(m_clk_divider_valid), .m_clk_divider_o(m_clk_divider),
    .m_cpol_o(m_cpol), .m_cpha_o(m_cpha),
    .m_busy_i(m_busy), .m_rx_data_valid_i(m_rx_data_valid), .m_rx_data_i(m_rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  // Requester side: per-port byte queues plus burst lengths.
  logic [7:0] q_data[2][$];
  bit         q_last[2][$];
  int         bl[2][$];
  bit         hold[2];
  int         vrise[2];
  bit         mute = 1'b0;
  logic [7:0] mask = 8'h00;

  // Observed events.
  int div_log[$], cp_log[$], div_cyc[$], tx_log[$], tx_cyc[$], rx_cyc[$];
  int rsp_log[$], rsp_cyc[$], ov_log[$];
  int rdy_cnt[2];
  int err_cnt = 0;
  int err_cyc = 0;

  // Expected events.
  int exp_div[$], exp_cp[$], exp_tx[$], exp_rsp[$], exp_ov[$];
  int exp_rdy[2];
  int exp_last = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < 2; p++) begin
      q_data[p].delete(); q_last[p].delete(); bl[p].delete();
      rdy_cnt[p] = 0; exp_rdy[p] = 0; hold[p] = 1'b0;
    end
    div_log.delete(); cp_log.delete(); div_cyc.delete(); tx_log.delete(); tx_cyc.delete();
    rx_cyc.delete(); rsp_log.delete(); rsp_cyc.delete(); ov_log.delete();
    exp_div.delete(); exp_cp.delete(); exp_tx.delete(); exp_rsp.delete(); exp_ov.delete();
  endtask

  task automatic add_burst(input int p, input int len);
    for (int k = 0; k < len; k++) begin
      q_data[p].push_back(8'($urandom_range(255, 0)));
      q_last[p].push_back(k == len - 1);
    end
    bl[p].push_back(len);
  endtask

  // Expected schedule: whole bursts, round robin when both ports have work pending.
  task automatic plan();
    int bi[2];
    int di[2];
    int p, len;
    logic [7:0] d;
    bit h0, h1;
    bi[0] = 0; bi[1] = 0; di[0] = 0; di[1] = 0;
    while (bi[0] < bl[0].size() || bi[1] < bl[1].size()) begin
      h0 = bi[0] < bl[0].size();
      h1 = bi[1] < bl[1].size();
      if (h0 && h1) p = 1 - exp_last;
      else p = h0 ? 0 : 1;
      exp_div.push_back(int'(cfg_div[p]));
      exp_cp.push_back(int'({cfg_cpol[p], cfg_cpha[p]}));
      len = bl[p][bi[p]];
      for (int k = 0; k < len; k++) begin
        d = q_data[p][di[p]];
        exp_tx.push_back(p * 256 + int'(d));
        exp_rsp.push_back(p * 256 + int'(d ^ mask));
        exp_ov.push_back((k == len - 1) ? 0 : 1);
        di[p]++;
        exp_rdy[p]++;
      end
      bi[p]++;
      exp_last = p;
    end
  endtask

  task automatic compare(input string tn);
    chk({tn, " div_count"}, div_log.size(), exp_div.size());
    for (int i = 0; i < div_log.size() && i < exp_div.size(); i++) begin
      chk({tn, " div"}, div_log[i], exp_div[i]);
      chk({tn, " cpol_cpha"}, cp_log[i], exp_cp[i]);
    end
    chk({tn, " tx_count"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      chk({tn, " tx_owner_data"}, tx_log[i], exp_tx[i]);
    chk({tn, " rsp_count"}, rsp_log.size(), exp_rsp.size());
    for (int i = 0; i < rsp_log.size() && i < exp_rsp.size(); i++) begin
      chk({tn, " rsp_port_data"}, rsp_log[i], exp_rsp[i]);
      chk({tn, " owner_valid_at_rsp"}, ov_log[i], exp_ov[i]);
    end
    chk({tn, " ready0_count"}, rdy_cnt[0], exp_rdy[0]);
    chk({tn, " ready1_count"}, rdy_cnt[1], exp_rdy[1]);
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (rsp_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (IdleGap + 3) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  // Requester drivers: hold a byte until its req_ready pulse has been seen.
  initial begin
    logic [1:0] rdy;
    logic [1:0] prev_v;
    req_valid = '0; req_data = '0; req_last = '0; prev_v = '0;
    forever begin
      @(posedge clk);
      rdy = req_ready;
      #1;
      for (int p = 0; p < 2; p++) begin
        if (rdy[p] && q_data[p].size() > 0) begin
          void'(q_data[p].pop_front());
          void'(q_last[p].pop_front());
        end
        req_valid[p] = !hold[p] && (q_data[p].size() > 0);
        req_data[p]  = (q_data[p].size() > 0) ? q_data[p][0] : 8'h00;
        req_last[p]  = (q_last[p].size() > 0) ? q_last[p][0] : 1'b0;
        if (req_valid[p] && !prev_v[p]) vrise[p] = cyc;
        prev_v[p] = req_valid[p];
      end
    end
  end

  // spi_master stand-in: MOSI looped to MISO through an xor mask, random transfer length.
  initial begin
    logic tv, rs;
    logic [7:0] td, sh;
    int busy_cnt;
    m_busy = 1'b0; m_rx_data_valid = 1'b0; m_rx_data = 8'h00; busy_cnt = 0; sh = 8'h00;
    forever begin
      @(posedge clk);
      tv = m_tx_data_valid; td = m_tx_data; rs = rst_n;
      #1;
      m_rx_data_valid = 1'b0;
      if (!rs) begin
        m_busy = 1'b0;
        busy_cnt = 0;
      end else if (tv) begin
        m_busy = 1'b1;
        busy_cnt = $urandom_range(6, 3);
        sh = td;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          m_busy = 1'b0;
          if (!mute) begin
            m_rx_data_valid = 1'b1;
            m_rx_data = sh ^ mask;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_clk_divider_valid) begin
        div_log.push_back(int'(m_clk_divider));
        cp_log.push_back(int'({m_cpol, m_cpha}));
        div_cyc.push_back(cyc);
      end
      if (m_tx_data_valid) begin
        tx_log.push_back(int'(owner) * 256 + int'(m_tx_data));
        tx_cyc.push_back(cyc);
      end
      if (m_rx_data_valid) rx_cyc.push_back(cyc);
      for (int p = 0; p < 2; p++) begin
        if (req_ready[p]) rdy_cnt[p]++;
        if (rsp_valid[p]) begin
          rsp_log.push_back(p * 256 + int'(rsp_data));
          rsp_cyc.push_back(cyc);
          ov_log.push_back(int'(owner_valid));
        end
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    cfg_div = '0; cfg_cpol = '0; cfg_cpha = '0;
    hold[0] = 1'b0; hold[1] = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {req_ready, rsp_valid, owner_valid, owner, err, m_tx_data_valid,
                       m_clk_divider_valid, m_cpol, m_cpha}, 64'h0);
    chk("reset_data", {rsp_data, m_tx_data, m_clk_divider}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte on port 0, plain loopback.
    clear_all();
    mask = 8'h00;
    cfg_div[0] = 8'd4; cfg_div[1] = 8'd10;
    cfg_cpol = 2'($urandom_range(3, 0)); cfg_cpha = 2'($urandom_range(3, 0));
    add_burst(0, 1);
    q_data[0][0] = 8'hA5;
    plan();
    wait_rsp(1, 60);
    compare("single");
    if (div_cyc.size() > 0) chk("single div_latency", div_cyc[0], vrise[0] + 1);
    if (tx_cyc.size() > 0) chk("single tx_latency", tx_cyc[0], vrise[0] + 2);
    if (rsp_cyc.size() > 0 && rx_cyc.size() > 0) chk("single rsp_latency", rsp_cyc[0], rx_cyc[0] + 1);
    chk("single owner_valid_after", owner_valid, 1'b0);

    // Three-byte burst on port 1 while port 0 waits throughout.
    clear_all();
    mask = 8'($urandom_range(255, 0));
    add_burst(1, 3);
    q_data[1][0] = 8'h11; q_data[1][1] = 8'h22; q_data[1][2] = 8'h33;
    add_burst(0, 1);
    plan();
    wait_rsp(4, 200);
    compare("burst3");
    if (div_cyc.size() > 1 && rsp_cyc.size() > 2)
      chk("burst3 gap", div_cyc[1] - rsp_cyc[2], IdleGap + 1);

    // From reset, both ports always pending: grants alternate 0,1,0,1,...
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_last = 1;
    clear_all();
    mask = 8'($urandom_range(255, 0));
    cfg_div[0] = 8'd4; cfg_div[1] = 8'd10;
    cfg_cpol = 2'($urandom_range(3, 0)); cfg_cpha = 2'($urandom_range(3, 0));
    for (int i = 0; i < 3; i++) begin
      add_burst(0, 1);
      add_burst(1, 1);
    end
    plan();
    wait_rsp(6, 300);
    compare("alternate");
    for (int k = 0; k + 1 < div_cyc.size() && k < rsp_cyc.size(); k++)
      chk("alternate gap", div_cyc[k + 1] - rsp_cyc[k], IdleGap + 1);

    // Owner stalls mid-burst for 50 cycles; port 1 must stay locked out.
    clear_all();
    mask = 8'($urandom_range(255, 0));
    cfg_div[0] = 8'($urandom_range(255, 1)); cfg_div[1] = 8'($urandom_range(255, 1));
    add_burst(0, 3);
    add_burst(1, 2);
    plan();
    wait_tx(1, 40);
    hold[0] = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("stall tx_count", tx_log.size(), 1);
    chk("stall owner", owner, 1'b0);
    chk("stall owner_valid", owner_valid, 1'b1);
    chk("stall ready1", rdy_cnt[1], 0);
    hold[0] = 1'b0;
    wait_rsp(5, 300);
    compare("stall");

    // Reset while a byte is in flight: no response, pointer back to port 0.
    clear_all();
    mask = 8'($urandom_range(255, 0));
    add_burst(0, 1);
    plan();
    wait_rsp(1, 60);
    compare("pre_reset");
    clear_all();
    add_burst(1, 1);
    wait_tx(1, 60);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_ctrl", {req_ready, rsp_valid, owner_valid, owner, err, m_tx_data_valid,
                          m_clk_divider_valid, m_cpol, m_cpha}, 64'h0);
    chk("midreset_data", {rsp_data, m_tx_data, m_clk_divider}, 64'h0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midreset no_rsp", rsp_log.size(), 0);
    clear_all();
    exp_last = 1;
    add_burst(1, 1);
    add_burst(0, 1);
    plan();
    wait_rsp(2, 100);
    compare("post_reset");
    if (tx_log.size() > 0) chk("post_reset first_owner", tx_log[0] / 256, 0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: no MISO byte ever returns.
    clear_all();
    mute = 1'b1;
    add_burst(0, 1);
    wait_tx(1, 40);
    t = (tx_cyc.size() > 0) ? tx_cyc[0] : 0;
    repeat (30) @(posedge clk);
    #1;
    chk("timeout err_cycle", err_cyc, t + 17);
    chk("timeout no_rsp", rsp_log.size(), 0);
    chk("timeout owner_valid", owner_valid, 1'b0);
    mute = 1'b0;
    chk("err_pulses", err_cnt, 1);
`else
    t = 0;
    chk("err_pulses", err_cnt + t, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
